// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding and requester port ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache ports,
// the arbiter and the block memory.
interface mem_arbiter_if #(
  parameter int ADDR_SIZE  = 24,
  parameter int BLOCK_BITS = 128
);

  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_SIZE-1:0]  p0_addr;
  logic [BLOCK_BITS-1:0] p0_wdata;
  logic [BLOCK_BITS-1:0] p0_rdata;
  logic                  p0_done;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_SIZE-1:0]  p1_addr;
  logic [BLOCK_BITS-1:0] p1_wdata;
  logic [BLOCK_BITS-1:0] p1_rdata;
  logic                  p1_done;

  logic [ADDR_SIZE-1:0]  mem_addr;
  logic                  mem_r;
  logic                  mem_w;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [BLOCK_BITS-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_done,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_done,
    output mem_addr, mem_r, mem_w, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_done,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_done,
    input  mem_addr, mem_r, mem_w, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant decision for two requesters; on a tie
// the port that is not 'last' wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  // Tie goes to the port opposite the pointer.
  always_comb begin
    grant = PORT_I;
    unique case (1'b1)
      req0 && req1:  grant = ~last;
      req1 && !req0: grant = PORT_D;
      default:       grant = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port block memory arbiter (icache p0, dcache p1).
// Define MEM_ARBITER_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 24,
  parameter int BLOCK_BITS = 128
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.master bus
);

  state_t                state;
  logic                  id;
  logic                  we;
  logic                  grant;
  logic                  last;
  logic                  any_req;
  logic                  sel_we;
  logic [ADDR_SIZE-1:0]  sel_addr;
  logic [BLOCK_BITS-1:0] sel_wdata;

  assign any_req = bus.p0_req | bus.p1_req;

  assign sel_we    = grant ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = grant ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant ? bus.p1_wdata : bus.p0_wdata;

  mem_arb_pick u_pick (
    .req0  (bus.p0_req),
    .req1  (bus.p1_req),
    .last  (last),
    .grant (grant)
  );

`ifdef MEM_ARBITER_RR_EN
  logic last_q;

  // Remember who finished last; reset favours p0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_q <= PORT_D;
    else if (state == DONE)
      last_q <= id;
  end

  assign last = last_q;
`else
  assign last = PORT_I;
`endif

  // Transfer sequencing with registered strobes and responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      id            <= PORT_I;
      we            <= 1'b0;
      bus.mem_r     <= 1'b0;
      bus.mem_w     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.p0_done   <= 1'b0;
      bus.p1_done   <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req && bus.mem_ready) begin
            id            <= grant;
            we            <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_r     <= ~sel_we;
            bus.mem_w     <= sel_we;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.mem_ready) begin
            bus.mem_r <= 1'b0;
            bus.mem_w <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            if (id == PORT_D) begin
              if (!we) bus.p1_rdata <= bus.mem_rdata;
              bus.p1_done <= 1'b1;
            end else begin
              if (!we) bus.p0_rdata <= bus.mem_rdata;
              bus.p0_done <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          bus.p0_done <= 1'b0;
          bus.p1_done <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 24, block address width.
REQ-002 Parameter BLOCK_BITS, default 128, block data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 p0_req / p1_req  input  1  port request (p0 = instruction cache, p1 = data cache); held until matching done.
REQ-006 p0_we / p1_we  input  1  1 = block write, 0 = block read; valid while req high.
REQ-007 p0_addr / p1_addr  input  ADDR_SIZE  block address.
REQ-008 p0_wdata / p1_wdata  input  BLOCK_BITS  write block.
REQ-009 p0_rdata / p1_rdata  output  BLOCK_BITS  read block; valid in the done cycle.
REQ-010 p0_done / p1_done  output  1  one-cycle completion pulse.
REQ-011 mem_addr  output  ADDR_SIZE  address to memory.
REQ-012 mem_r / mem_w  output  1  read / write strobe to memory.
REQ-013 mem_wdata  output  BLOCK_BITS  write data to memory.
REQ-014 mem_rdata  input  BLOCK_BITS  read data from memory.
REQ-015 mem_ready  input  1  memory idle (1) / busy (0).

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any req and mem_ready=1, latch the winner's id, we, addr and wdata, then go to ISSUE; otherwise stay.
REQ-018 ISSUE: drive mem_r=~we or mem_w=we from the latched values; hold the strobe until mem_ready=0 is sampled, then go to WAIT.
REQ-019 WAIT: strobes low; on mem_ready=1, capture mem_rdata (reads only) into the winner's rdata register, then go to DONE.
REQ-020 DONE: pulse the winner's done for exactly one cycle, then go to IDLE.
REQ-021 Minimum latency from req sampled to done is 4 cycles; request-to-done is otherwise unbounded and follows memory delay.
REQ-022 mem_addr and mem_wdata come from the latched values and are stable from ISSUE through WAIT.
REQ-023 Requester inputs may change after the grant without affecting the transfer in flight.
REQ-024 The non-granted port's rdata holds its previous value, and its done stays 0.
REQ-025 Write transactions leave the granted port's rdata unchanged.
REQ-026 Default arbitration is fixed priority: p1 wins when both req are high in the same IDLE cycle.
REQ-027 A request that is not granted stays pending and is served in a later IDLE cycle; it is never dropped.
REQ-028 mem_r and mem_w are never both 1.

Reset
REQ-029 rst_n=0 asynchronously forces state=IDLE, mem_r=0, mem_w=0, p0_done=0, p1_done=0, mem_addr=0, mem_wdata=0, p0_rdata=0, p1_rdata=0, and the round-robin pointer (when built) to p0-preferred.
REQ-030 Reset during ISSUE, WAIT or DONE aborts the transfer: no done pulse, and the requester must re-request.
REQ-031 Release of rst_n takes effect on the next rising clk edge.

Configuration
REQ-032 Macro MEM_ARBITER_RR_EN defined: round-robin arbitration with a 1-bit last-grant pointer, updated in DONE; on a tie the port not granted last wins.
REQ-033 MEM_ARBITER_RR_EN undefined: fixed priority as in REQ-026, with no pointer register.

Structure
REQ-034 Shared package mem_arb_pkg holds the FSM state enum and the port-id constants PORT_I=0 and PORT_D=1.
REQ-035 Single module; arbitration decision in sub-module mem_arb_pick (two requests plus pointer in, grant id out).

Verification
REQ-036 p0 reads addr 0x000010 with memory returning 0xDEADBEEF_00000000_00000000_12345678 after 5 busy cycles -> one p0_done pulse, p0_rdata equals that value, mem_r high only in ISSUE.
REQ-037 p1 writes 0xA5 repeated to addr 0x0000FF -> mem_w=1, mem_addr=0x0000FF, mem_wdata stable until mem_ready rises, p1_done pulse, p1_rdata unchanged.
REQ-038 Both req high in the same IDLE cycle for three back-to-back transfers -> fixed build: p1 serviced each time while held; RR build: grant order p0, p1, p0.
REQ-039 mem_ready held 0 when p0_req rises -> state stays IDLE, no strobe; mem_ready set to 1 -> ISSUE next cycle.
REQ-040 rst_n pulsed low mid-WAIT -> all outputs 0 immediately, no done pulse, and the next request is served normally.
REQ-041 p0 changes addr to 0x000020 one cycle after the grant -> mem_addr stays 0x000010 until done.
